// File: rtl/ascon_p_multimode.sv
// Ascon permutation core: 320-bit state loaded and read one 64-bit word per cycle,
// running p^12, p^8 or p^6 with UNROLL rounds evaluated per clock.
module ascon_p_multimode #(
    parameter int BW     = 64,
    parameter int UNROLL = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load_en,
    input  logic [2:0]    slice_idx,
    input  logic [BW-1:0] slice_in,
    input  logic          start,
    input  logic [1:0]    nr_sel,
    output logic          busy,
    output logic          done,
    output logic [BW-1:0] slice_out,
    output logic [3:0]    round_idx
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_e;
    typedef logic [4:0][63:0] state_t;

    localparam logic [4:0] UNROLL_W = 5'(UNROLL);

    if (BW != 64) begin : g_bad_bw
        $error("ascon_p_multimode: BW must be 64");
    end
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 3 && UNROLL != 4 && UNROLL != 6 && UNROLL != 12) begin : g_bad_unroll
        $error("ascon_p_multimode: UNROLL must be one of 1, 2, 3, 4, 6, 12");
    end

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        rotr = (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon round; indices past the last round leave the state untouched.
    function automatic state_t ascon_round(input state_t s, input logic [4:0] idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        logic [3:0]  i;
        state_t      r;
        i  = idx[3:0];
        x0 = s[0];
        x1 = s[1];
        x2 = s[2] ^ {56'h0, 4'hF - i, i};
        x3 = s[3];
        x4 = s[4];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        r[0] = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        r[1] = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        r[2] = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        r[3] = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        r[4] = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        if (idx >= 5'd12) begin
            ascon_round = s;
        end else begin
            ascon_round = r;
        end
    endfunction

    fsm_e          fsm_q, fsm_d;
    state_t        st_q, st_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [BW-1:0] slice_out_q, slice_out_d;
    logic [3:0]    round_idx_q, round_idx_d;
    logic [3:0]    first_idx_s;
    state_t        chain_s [UNROLL+1];

    // Unrolled round chain: stage k evaluates round index round_idx_q + k.
    always_comb begin
        chain_s[0] = st_q;
        for (int k = 0; k < UNROLL; k++) begin
            chain_s[k+1] = ascon_round(chain_s[k], {1'b0, round_idx_q} + 5'(k));
        end
    end

    // First round-constant index for the requested round count.
    always_comb begin
        case (nr_sel)
            2'b01:   first_idx_s = 4'd4;
            2'b10:   first_idx_s = 4'd6;
            default: first_idx_s = 4'd0;
        endcase
    end

    // Next-state logic for the FSM, state words and registered outputs.
    always_comb begin
        fsm_d       = fsm_q;
        st_d        = st_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        round_idx_d = round_idx_q;
        slice_out_d = (slice_idx < 3'd5) ? st_q[slice_idx] : 64'h0;
        case (fsm_q)
            IDLE: begin
                busy_d      = 1'b0;
                round_idx_d = 4'd12;
                if (load_en) begin
                    if (slice_idx < 3'd5) begin
                        st_d[slice_idx] = slice_in;
                    end else begin
                        st_d = st_q;
                    end
                end else if (start) begin
                    round_idx_d = first_idx_s;
                    busy_d      = 1'b1;
                    fsm_d       = RUN;
                end else begin
                    fsm_d = IDLE;
                end
            end
            RUN: begin
                st_d = chain_s[UNROLL];
                if (({1'b0, round_idx_q} + UNROLL_W) >= 5'd12) begin
                    fsm_d       = IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    round_idx_d = 4'd12;
                end else begin
                    round_idx_d = round_idx_q + UNROLL_W[3:0];
                end
            end
            default: begin
                fsm_d       = IDLE;
                busy_d      = 1'b0;
                round_idx_d = 4'd12;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_q       <= IDLE;
            st_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            round_idx_q <= 4'd12;
            slice_out_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            st_q        <= st_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            round_idx_q <= round_idx_d;
            slice_out_q <= slice_out_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign slice_out = slice_out_q;
    assign round_idx = round_idx_q;

endmodule

// File: tb/tb_ascon_p_multimode.sv
// Bench for ascon_p_multimode: six instances (UNROLL 1,2,3,4,6,12) on shared stimulus,
// checked against an S-box-table reference permutation.
`timescale 1ns/1ps
module tb_ascon_p_multimode;

    typedef logic [4:0][63:0] st_t;
    localparam int NI = 6;

    function automatic int unroll_of(input int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            4: return 6;
            default: return 12;
        endcase
    endfunction

    logic                clk = 1'b0;
    logic                rstn, load_en, start;
    logic [2:0]          slice_idx;
    logic [63:0]         slice_in;
    logic [1:0]          nr_sel;
    logic [NI-1:0]       busy_v, done_v;
    logic [NI-1:0][63:0] slice_out_v;
    logic [NI-1:0][3:0]  round_idx_v;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [4:0] sbox_tab [32];
    st_t        vec;
    int         busy_len [NI];
    int         last_busy [NI];
    int         done_cnt [NI];
    int         done_at [NI];
    logic [3:0] ri_log [NI][20];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int U = unroll_of(g);
        ascon_p_multimode #(.BW(64), .UNROLL(U)) u_dut (
            .clk(clk), .rstn(rstn), .load_en(load_en), .slice_idx(slice_idx),
            .slice_in(slice_in), .start(start), .nr_sel(nr_sel),
            .busy(busy_v[g]), .done(done_v[g]), .slice_out(slice_out_v[g]),
            .round_idx(round_idx_v[g])
        );
    end

    function automatic int nr_count(input logic [1:0] s);
        return (s == 2'b01) ? 8 : (s == 2'b10) ? 6 : 12;
    endfunction

    function automatic logic [63:0] rot(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    // Reference: last nr rounds of Ascon, S-box applied column by column from its table.
    function automatic st_t model_perm(input st_t s, input int nr);
        st_t        x;
        logic [4:0] col;
        int         ra [5] = '{19, 61, 1, 10, 7};
        int         rb [5] = '{28, 39, 6, 17, 41};
        x = s;
        for (int r = 12 - nr; r < 12; r++) begin
            x[2][7:0] = x[2][7:0] ^ 8'((15 - r) * 16 + r);
            for (int b = 0; b < 64; b++) begin
                col = sbox_tab[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
                for (int w = 0; w < 5; w++) x[w][b] = col[4 - w];
            end
            for (int w = 0; w < 5; w++) x[w] = x[w] ^ rot(x[w], ra[w]) ^ rot(x[w], rb[w]);
        end
        return x;
    endfunction

    task automatic load_state(input st_t s);
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            load_en = 1'b1; slice_idx = 3'(w); slice_in = s[w];
        end
        @(negedge clk);
        load_en = 1'b0; slice_in = 64'h0;
    endtask

    task automatic read_state(input int g, output st_t s);
        for (int w = 0; w < 5; w++) begin
            @(negedge clk); slice_idx = 3'(w);
            @(negedge clk); s[w] = slice_out_v[g];
        end
    endtask

    // Pulse start, then log busy/done/round_idx over a fixed 20-cycle window; optional mid-run poke.
    task automatic run_perm(input logic [1:0] nr, input int inject_cyc);
        @(negedge clk); start = 1'b1; nr_sel = nr;
        @(negedge clk); start = 1'b0; nr_sel = 2'($urandom_range(0, 3));
        for (int g = 0; g < NI; g++) begin
            busy_len[g] = 0; last_busy[g] = -1; done_cnt[g] = 0; done_at[g] = -1;
        end
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            load_en = 1'b0; start = 1'b0;
            for (int g = 0; g < NI; g++) begin
                ri_log[g][c] = round_idx_v[g];
                if (busy_v[g]) begin busy_len[g]++; last_busy[g] = c; end
                if (done_v[g]) begin done_cnt[g]++; done_at[g] = c; end
            end
            if (c == inject_cyc) begin
                load_en = 1'b1; start = 1'b1; slice_in = '1; slice_idx = 3'($urandom_range(0, 4));
            end
        end
    endtask

    task automatic test_reset();
        st_t got;
        rstn = 1'b0; load_en = 1'b0; start = 1'b0; slice_idx = 3'd0; slice_in = 64'h0; nr_sel = 2'b00;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            n_cmp++;
            if ({busy_v[g], done_v[g], round_idx_v[g], slice_out_v[g]} !== {1'b0, 1'b0, 4'd12, 64'h0}) begin
                n_err++;
                $display("FAIL reset_outputs g=%0d: got busy=%b done=%b ri=%0d so=%h want 0 0 12 0",
                         g, busy_v[g], done_v[g], round_idx_v[g], slice_out_v[g]);
            end
        end
        @(negedge clk); rstn = 1'b1;
        read_state(0, got);
        n_cmp++;
        if (got !== '0) begin
            n_err++; $display("FAIL reset_state: got %h want 0", got);
        end
    endtask

    task automatic test_perm_modes();
        st_t        s, got, exp;
        logic [1:0] nr;
        int         nrn, len, u;
        logic       ri_bad;
        for (int t = 0; t < 6; t++) begin
            if (t < 3) s = vec;
            else for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
            case (t)
                0: nr = 2'b00;
                1: nr = 2'b10;
                2: nr = 2'b01;
                3: nr = 2'b11;
                default: nr = 2'($urandom_range(0, 3));
            endcase
            nrn = nr_count(nr);
            exp = model_perm(s, nrn);
            load_state(s);
            run_perm(nr, -1);
            for (int g = 0; g < NI; g++) begin
                u   = unroll_of(g);
                len = (nrn + u - 1) / u;
                n_cmp++;
                if (busy_len[g] !== len || last_busy[g] !== len - 1) begin
                    n_err++;
                    $display("FAIL busy_len t=%0d U=%0d: got %0d (last %0d) want %0d", t, u, busy_len[g], last_busy[g], len);
                end
                n_cmp++;
                if (done_cnt[g] !== 1 || done_at[g] !== len) begin
                    n_err++;
                    $display("FAIL done_pulse t=%0d U=%0d: got count %0d at %0d want 1 at %0d", t, u, done_cnt[g], done_at[g], len);
                end
                ri_bad = 1'b0;
                for (int c = 0; c <= len; c++)
                    if (ri_log[g][c] !== ((c < len) ? 4'(12 - nrn + u * c) : 4'd12)) ri_bad = 1'b1;
                n_cmp++;
                if (ri_bad) begin
                    n_err++;
                    $display("FAIL round_idx_seq t=%0d U=%0d: got %0d,%0d,%0d,%0d want start %0d step %0d",
                             t, u, ri_log[g][0], ri_log[g][1], ri_log[g][2], ri_log[g][3], 12 - nrn, u);
                end
                read_state(g, got);
                n_cmp++;
                if (got !== exp) begin
                    n_err++; $display("FAIL perm_out t=%0d U=%0d nr=%0d: got %h want %h", t, u, nrn, got, exp);
                end
            end
        end
    endtask

    task automatic test_run_inject();
        st_t got, exp;
        exp = model_perm(vec, 12);
        load_state(vec);
        run_perm(2'b00, 3);
        for (int g = 0; g < NI; g++) begin
            n_cmp++;
            if (done_cnt[g] !== 1) begin
                n_err++; $display("FAIL inject_single_run g=%0d: got %0d done pulses want 1", g, done_cnt[g]);
            end
        end
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if (busy_len[g] !== (12 + unroll_of(g) - 1) / unroll_of(g)) begin
                n_err++; $display("FAIL inject_busy g=%0d: got %0d", g, busy_len[g]);
            end
            read_state(g, got);
            n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL inject_out g=%0d: got %h want %h", g, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        st_t  got;
        logic seen;
        load_state(vec);
        @(negedge clk); start = 1'b1; nr_sel = 2'b00;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (busy_v !== '0 || done_v !== '0 || round_idx_v !== {NI{4'd12}}) begin
            n_err++; $display("FAIL midrun_reset: got busy=%b done=%b ri=%h want 0 0 all-c", busy_v, done_v, round_idx_v);
        end
        @(negedge clk); rstn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((|busy_v) || (|done_v)) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++; $display("FAIL midrun_no_done: got busy/done activity after reset want none");
        end
        for (int g = 0; g < NI; g++) begin
            read_state(g, got);
            n_cmp++;
            if (got !== '0) begin
                n_err++; $display("FAIL midrun_state g=%0d: got %h want 0", g, got);
            end
        end
    endtask

    task automatic test_back_to_back();
        st_t  got, exp;
        logic got_done;
        exp = model_perm(model_perm(vec, 6), 6);
        load_state(vec);
        @(negedge clk); start = 1'b1; nr_sel = 2'b10;
        @(negedge clk); start = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!got_done) begin
                @(negedge clk); got_done = done_v[0];
            end
        end
        n_cmp++;
        if (!got_done) begin
            n_err++; $display("FAIL b2b_first_done: got no done want done");
        end
        start = 1'b1; nr_sel = 2'b10;
        @(negedge clk); start = 1'b0;
        n_cmp++;
        if (busy_v[0] !== 1'b1 || round_idx_v[0] !== 4'd6) begin
            n_err++; $display("FAIL b2b_restart: got busy=%b ri=%0d want 1 6", busy_v[0], round_idx_v[0]);
        end
        repeat (20) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            read_state(g, got);
            n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL b2b_out g=%0d: got %h want %h", g, got, exp);
            end
        end
    endtask

    task automatic test_load_start_idle();
        st_t         got, exp;
        logic [63:0] d1;
        logic        seen;
        d1 = {$urandom(), $urandom()};
        exp = vec;
        exp[1] = d1;
        load_state(vec);
        @(negedge clk); load_en = 1'b1; start = 1'b1; nr_sel = 2'b00; slice_idx = 3'd1; slice_in = d1;
        @(negedge clk); load_en = 1'b0; start = 1'b0; slice_in = {$urandom(), $urandom()};
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (|busy_v) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++; $display("FAIL load_start_busy: got busy want idle");
        end
        @(negedge clk); load_en = 1'b1; slice_idx = 3'd6; slice_in = {$urandom(), $urandom()};
        @(negedge clk); load_en = 1'b0;
        for (int g = 0; g < NI; g++) begin
            read_state(g, got);
            n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL load_wins g=%0d: got %h want %h", g, got, exp);
            end
        end
        for (int k = 5; k < 8; k++) begin
            @(negedge clk); slice_idx = 3'(k);
            @(negedge clk);
            n_cmp++;
            if (slice_out_v !== '0) begin
                n_err++; $display("FAIL read_oob idx=%0d: got %h want 0", k, slice_out_v);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sbox_tab = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                     5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                     5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                     5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
        vec    = '0;
        vec[0] = 64'h0000000080400c06;
        test_reset();
        test_perm_modes();
        test_run_inject();
        test_reset_mid_run();
        test_back_to_back();
        test_load_start_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
